// File: rtl/forward_neuron_pkg.sv
// Shared definitions for the forward neuron stage: FSM encoding, width helpers
// and the field offsets of the bias/weight bundle layout.
package forward_neuron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } stateT;

    // Ceiling log2 used for counter and accumulator sizing (clog2(1) = 0).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

    // Accumulator width: full product plus enough guard bits for NP terms and the bias.
    function automatic int accWidth(input int wf, input int np);
        return 2 * wf + clog2(np + 1);
    endfunction

    // Offset of b_j inside the WeightBias bundle.
    function automatic int wbBiasOffset(input int j, input int wf);
        return j * wf;
    endfunction

    // Offset of w_ij inside the WeightBias bundle (biases first, then rows of NC weights).
    function automatic int wbWeightOffset(input int i, input int j, input int nc, input int wf);
        return nc * wf + i * nc * wf + j * wf;
    endfunction

endpackage

// File: rtl/forward_neuron_if.sv
// Stream bundle for the forward neuron: activation in, bias/weight bundle in, result out.
interface forward_neuron_if #(
    parameter int NP = 3,
    parameter int NC = 2,
    parameter int WF = 8
);
    logic                      iValid_AS_State;
    logic                      oReady_AS_State;
    logic [NP*WF-1:0]          iData_AS_State;
    logic                      iValid_AS_WeightBias;
    logic                      oReady_AS_WeightBias;
    logic [NC*NP*WF+NC*WF-1:0] iData_AS_WeightBias;
    logic                      oValid_BM_State;
    logic                      iReady_BM_State;
    logic [NC*WF-1:0]          oData_BM_State;
    logic [NC-1:0]             oData_BM_Mask;

    // Neuron side
    modport slave (
        input  iValid_AS_State, iData_AS_State,
        input  iValid_AS_WeightBias, iData_AS_WeightBias,
        input  iReady_BM_State,
        output oReady_AS_State, oReady_AS_WeightBias,
        output oValid_BM_State, oData_BM_State, oData_BM_Mask
    );

    // Producer/consumer side
    modport master (
        output iValid_AS_State, iData_AS_State,
        output iValid_AS_WeightBias, iData_AS_WeightBias,
        output iReady_BM_State,
        input  oReady_AS_State, oReady_AS_WeightBias,
        input  oValid_BM_State, oData_BM_State, oData_BM_Mask
    );
endinterface

// File: rtl/forward_neuron_mac_lane.sv
// One output neuron: signed MAC accumulator plus rescale, ReLU and saturation.
module forward_neuron_mac_lane #(
    parameter int WF   = 8,
    parameter int FRAC = 4,
    parameter int WA   = 18
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iLoad,
    input  logic                 iEn,
    input  logic                 iLast,
    input  logic signed [WF-1:0] iBias,
    input  logic signed [WF-1:0] iX,
    input  logic signed [WF-1:0] iW,
    output logic        [WF-1:0] oY,
    output logic                 oMask
);
    localparam logic signed [WA-1:0] YMAX = {{(WA-WF+1){1'b0}}, {(WF-1){1'b1}}};

    logic signed [WA-1:0]   acc;
    logic signed [WA-1:0]   accNext;
    logic signed [WA-1:0]   accInit;
    logic signed [WA-1:0]   z;
    logic signed [2*WF-1:0] prod;
    logic        [WF-1:0]   yNext;
    logic                   maskNext;

    // Bias is aligned to the product's 2*FRAC fraction by shifting its own FRAC up.
    assign accInit = $signed({{(WA-WF){iBias[WF-1]}}, iBias}) <<< FRAC;
    assign prod    = iX * iW;
    assign accNext = acc + $signed({{(WA-2*WF){prod[2*WF-1]}}, prod});
    // The output is taken from the final sum so it can be registered on the last MAC edge.
    assign z       = accNext >>> FRAC;

    // ReLU with positive saturation; the mask marks a strictly positive pre-activation.
    always_comb begin
        maskNext = (z > 0);
        yNext    = '0;
        if (z > YMAX)   yNext = YMAX[WF-1:0];
        else if (z > 0) yNext = z[WF-1:0];
    end

    // Accumulator: bias preload on join, one term per CALC cycle.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)      acc <= '0;
        else if (iLoad) acc <= accInit;
        else if (iEn)   acc <= accNext;
    end

    // Result register, captured on the edge that enters DONE and held until the next one.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oY    <= '0;
            oMask <= 1'b0;
        end else if (iEn && iLast) begin
            oY    <= yNext;
            oMask <= maskNext;
        end
    end
endmodule

// File: rtl/forward_neuron.sv
// Forward-pass neuron stage: joins activations with a bias/weight bundle, runs NC MAC
// lanes serially over NP inputs, and returns ReLU activations plus the derivative mask.
module forward_neuron
    import forward_neuron_pkg::*;
#(
    parameter int NP   = 3,
    parameter int NC   = 2,
    parameter int WF   = 8,
    parameter int FRAC = 4
) (
    input logic       iCLK,
    input logic       iRST,
    forward_neuron_if.slave bus
);
    localparam int WA = accWidth(WF, NP);
    localparam int KW = (NP > 1) ? clog2(NP) : 1;

    stateT                        state;
    stateT                        stateNext;
    logic [KW-1:0]                k;
    logic [NP-1:0][WF-1:0]        xReg;
    logic [NP-1:0][NC-1:0][WF-1:0] wReg;
    logic [NC-1:0][WF-1:0]        bias;
    logic [NC-1:0][WF-1:0]        yArr;
    logic [NC-1:0]                maskArr;
    logic                         joinFire;
    logic                         macEn;
    logic                         lastK;

    assign bias  = bus.iData_AS_WeightBias[NC*WF-1:0];
    assign lastK = (k == KW'(NP - 1));

    // State register.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state: join in IDLE, NP MAC cycles, hold result until accepted.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (joinFire)            stateNext = CALC;
            CALC:    if (lastK)               stateNext = DONE;
            DONE:    if (bus.iReady_BM_State) stateNext = IDLE;
            default:                          stateNext = IDLE;
        endcase
    end

    // Outputs: each ready mirrors the opposite valid so both streams move together.
    always_comb begin
        bus.oReady_AS_State      = 1'b0;
        bus.oReady_AS_WeightBias = 1'b0;
        if (state == IDLE && iRST) begin
            bus.oReady_AS_State      = bus.iValid_AS_WeightBias;
            bus.oReady_AS_WeightBias = bus.iValid_AS_State;
        end
        joinFire            = (state == IDLE) && bus.iValid_AS_State && bus.iValid_AS_WeightBias;
        macEn               = (state == CALC);
        bus.oValid_BM_State = (state == DONE);
    end

    // Input index counter; restarts on every join.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)         k <= '0;
        else if (joinFire) k <= '0;
        else if (macEn)    k <= lastK ? '0 : k + 1'b1;
    end

    // Operand capture on join so upstream is free during CALC.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            xReg <= '0;
            wReg <= '0;
        end else if (joinFire) begin
            xReg <= bus.iData_AS_State;
            wReg <= bus.iData_AS_WeightBias[NC*NP*WF+NC*WF-1:NC*WF];
        end
    end

    for (genvar j = 0; j < NC; j++) begin : gLane
        forward_neuron_mac_lane #(
            .WF   (WF),
            .FRAC (FRAC),
            .WA   (WA)
        ) uLane (
            .iCLK  (iCLK),
            .iRST  (iRST),
            .iLoad (joinFire),
            .iEn   (macEn),
            .iLast (lastK),
            .iBias (bias[j]),
            .iX    (xReg[k]),
            .iW    (wReg[k][j]),
            .oY    (yArr[j]),
            .oMask (maskArr[j])
        );
    end

    assign bus.oData_BM_State = yArr;
    assign bus.oData_BM_Mask  = maskArr;
endmodule
